// File: rtl/envelope_bank_pkg.sv
// Shared types and helpers for the time-multiplexed ADSR envelope bank.
// Rates and sustain arrive as 7-bit percentages and are widened here.
package envelope_bank_pkg;

  localparam int ENVELOPE_COUNTER_WIDTH = 16;
  localparam int STEP_SHIFT             = 2;

  typedef logic [6:0]                        percent_t;
  typedef logic [ENVELOPE_COUNTER_WIDTH-1:0] level_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } envelope_state_t;

  localparam level_t LEVEL_MAX = '1;

  // 0 is the fastest rate: 128 - p spans 1..128, shifted up to 4..512.
  function automatic level_t rate_step(input percent_t p);
    logic [7:0] span;
    span = 8'd128 - {1'b0, p};
    return level_t'(span) << STEP_SHIFT;
  endfunction

  // Bit replication maps 0..127 onto the full 0..0xFFFF range.
  function automatic level_t sustain_level(input percent_t s);
    return {s, s, s[6:5]};
  endfunction

endpackage

// File: rtl/envelope_voice_step.sv
// Combinational next-state / next-level for one envelope voice.
// Evaluated once per sweep for the voice currently selected by the bank.
module envelope_voice_step
  import envelope_bank_pkg::*;
(
  input  logic [2:0]                        cur_state,
  input  logic [ENVELOPE_COUNTER_WIDTH-1:0] cur_level,
  input  logic                              gate,
  input  logic                              gate_prev,
  input  logic [6:0]                        attack,
  input  logic [6:0]                        decay,
  input  logic [6:0]                        sustain,
  input  logic [6:0]                        release_rate,
  output logic [2:0]                        next_state,
  output logic [ENVELOPE_COUNTER_WIDTH-1:0] next_level
);

  localparam int W = ENVELOPE_COUNTER_WIDTH;

  envelope_state_t state_now;
  envelope_state_t eff_state;
  envelope_state_t state_next;
  level_t          level_next;
  level_t          sustain_target;
  logic            rise;
  logic [W:0]      attack_sum;
  logic [W:0]      decay_diff;
  logic [W:0]      release_diff;

  assign state_now      = envelope_state_t'(cur_state);
  assign rise           = gate & ~gate_prev;
  assign sustain_target = sustain_level(sustain);

  // One bit of headroom so the saturation checks see carries and borrows.
  assign attack_sum   = {1'b0, cur_level} + {1'b0, rate_step(attack)};
  assign decay_diff   = {1'b0, cur_level} - {1'b0, rate_step(decay)};
  assign release_diff = {1'b0, cur_level} - {1'b0, rate_step(release_rate)};

  // Gate events redirect the state first, then that state's rate applies.
  always_comb begin
    eff_state = state_now;
    if (rise) begin
      eff_state = ATTACK;
    end else if (!gate && (state_now == ATTACK || state_now == DECAY ||
                           state_now == SUSTAIN)) begin
      eff_state = RELEASE;
    end
  end

  always_comb begin
    state_next = eff_state;
    level_next = cur_level;
    case (eff_state)
      IDLE: begin
        level_next = '0;
      end
      ATTACK: begin
        if (attack_sum >= {1'b0, LEVEL_MAX}) begin
          level_next = LEVEL_MAX;
          state_next = DECAY;
        end else begin
          level_next = attack_sum[W-1:0];
        end
      end
      DECAY: begin
        if (decay_diff[W] || decay_diff[W-1:0] <= sustain_target) begin
          level_next = sustain_target;
          state_next = SUSTAIN;
        end else begin
          level_next = decay_diff[W-1:0];
        end
      end
      SUSTAIN: begin
        level_next = sustain_target;
      end
      RELEASE: begin
        if (release_diff[W] || release_diff[W-1:0] == '0) begin
          level_next = '0;
          state_next = IDLE;
        end else begin
          level_next = release_diff[W-1:0];
        end
      end
      default: begin
        level_next = '0;
        state_next = IDLE;
      end
    endcase
  end

  assign next_state = state_next;
  assign next_level = level_next;

endmodule

// File: rtl/envelope_bank.sv
// Bank of linear ADSR envelopes sharing one update datapath.
// A tick starts a sweep that updates one voice per clock, then pulses done.
module envelope_bank
  import envelope_bank_pkg::*;
#(
  parameter  int NUM_VOICES  = 8,
  localparam int LEVEL_WIDTH = ENVELOPE_COUNTER_WIDTH
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              tick,
  input  logic [NUM_VOICES-1:0]             gate,
  input  logic [6:0]                        attack,
  input  logic [6:0]                        decay,
  input  logic [6:0]                        sustain,
  // "release" is a reserved word, hence the suffix.
  input  logic [6:0]                        release_rate,
  output logic [NUM_VOICES*LEVEL_WIDTH-1:0] level,
  output logic [NUM_VOICES-1:0]             active,
  output logic                              done,
  output logic                              overrun
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  logic             busy_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             done_reg;
  logic             overrun_reg;
  percent_t         attack_reg;
  percent_t         decay_reg;
  percent_t         sustain_reg;
  percent_t         release_reg;

  logic [3*NUM_VOICES-1:0] state_flat;
  logic [NUM_VOICES-1:0]   gate_prev_flat;

  logic [2:0]   cur_state;
  level_t       cur_level;
  logic         cur_gate;
  logic         cur_gate_prev;
  logic [2:0]   step_state;
  level_t       step_level;

  // Parameters are frozen for the whole sweep so every voice sees one set.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_reg    <= 1'b0;
      idx_reg     <= '0;
      done_reg    <= 1'b0;
      overrun_reg <= 1'b0;
      attack_reg  <= '0;
      decay_reg   <= '0;
      sustain_reg <= '0;
      release_reg <= '0;
    end else begin
      done_reg    <= 1'b0;
      overrun_reg <= tick & busy_reg;
      if (busy_reg) begin
        if (idx_reg == LAST_IDX) begin
          busy_reg <= 1'b0;
          idx_reg  <= '0;
          done_reg <= 1'b1;
        end else begin
          idx_reg <= idx_reg + 1'b1;
        end
      end else if (tick) begin
        busy_reg    <= 1'b1;
        idx_reg     <= '0;
        attack_reg  <= attack;
        decay_reg   <= decay;
        sustain_reg <= sustain;
        release_reg <= release_rate;
      end
    end
  end

  assign cur_state     = state_flat[idx_reg*3 +: 3];
  assign cur_level     = level[idx_reg*LEVEL_WIDTH +: LEVEL_WIDTH];
  assign cur_gate      = gate[idx_reg];
  assign cur_gate_prev = gate_prev_flat[idx_reg];

  envelope_voice_step u_step (
    .cur_state    (cur_state),
    .cur_level    (cur_level),
    .gate         (cur_gate),
    .gate_prev    (cur_gate_prev),
    .attack       (attack_reg),
    .decay        (decay_reg),
    .sustain      (sustain_reg),
    .release_rate (release_reg),
    .next_state   (step_state),
    .next_level   (step_level)
  );

  // Each voice owns its registers and only loads when the sweep points at it.
  for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : gen_voice
    logic [2:0] state_reg;
    level_t     level_reg;
    logic       gate_prev_reg;

    always_ff @(posedge clock) begin
      if (reset) begin
        state_reg     <= IDLE;
        level_reg     <= '0;
        gate_prev_reg <= 1'b0;
      end else if (busy_reg && idx_reg == IDX_W'(gi)) begin
        state_reg     <= step_state;
        level_reg     <= step_level;
        gate_prev_reg <= cur_gate;
      end
    end

    assign state_flat[gi*3 +: 3]                  = state_reg;
    assign gate_prev_flat[gi]                     = gate_prev_reg;
    assign level[gi*LEVEL_WIDTH +: LEVEL_WIDTH]   = level_reg;
    assign active[gi]                             = (state_reg != IDLE);
  end

  assign done    = done_reg;
  assign overrun = overrun_reg;

endmodule

// File: tb/tb_envelope_bank.sv
// Directed bench for envelope_bank: full ADSR cycle on voice 0, a concurrent
// envelope on voice 3, retrigger from a release level, overrun and mid-sweep reset.
module tb_envelope_bank;

  logic         clock;
  logic         reset;
  logic         tick;
  logic [7:0]   gate;
  logic [6:0]   attack;
  logic [6:0]   decay;
  logic [6:0]   sustain;
  logic [6:0]   release_rate;
  logic [127:0] level;
  logic [7:0]   active;
  logic         done;
  logic         overrun;

  int vectors;
  int miscompares;
  int ovr_seen;

  envelope_bank #(.NUM_VOICES(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .tick         (tick),
    .gate         (gate),
    .attack       (attack),
    .decay        (decay),
    .sustain      (sustain),
    .release_rate (release_rate),
    .level        (level),
    .active       (active),
    .done         (done),
    .overrun      (overrun)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  always @(negedge clock) if (overrun) ovr_seen++;

  function automatic logic [15:0] lvl(input int i);
    return level[i*16 +: 16];
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one tick and wait (bounded) for done; latency counted in cycles.
  task automatic do_tick();
    int lat;
    lat = 0;
    @(negedge clock);
    tick = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      tick = 1'b0;
      if (done) begin
        lat = c;
        break;
      end
    end
    check("done_latency", 128'(lat), 128'd9);
  endtask

  initial begin
    int done_at, done_cnt, ovr_at, ovr_cnt, done_after;
    vectors = 0; miscompares = 0; ovr_seen = 0;
    reset = 1'b1; tick = 1'b0; gate = '0;
    attack = 7'd0; decay = 7'd0; sustain = 7'd64; release_rate = 7'd0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("reset_level", level, 128'd0);
    check("reset_active", 128'(active), 128'd0);
    check("reset_done", 128'(done), 128'd0);
    check("reset_overrun", 128'(overrun), 128'd0);

    do_tick();
    check("idle_level", level, 128'd0);
    check("idle_active", 128'(active), 128'd0);

    gate[0] = 1'b1;
    for (int k = 1; k <= 128; k++) begin
      if (k == 101) gate[3] = 1'b1;
      do_tick();
      if (k == 1) begin
        check("atk1_lvl0", 128'(lvl(0)), 128'd512);
        check("atk1_active", 128'(active), 128'h01);
      end
      if (k == 64)  check("atk64_lvl0", 128'(lvl(0)), 128'h8000);
      if (k == 127) check("atk127_lvl0", 128'(lvl(0)), 128'hFE00);
      if (k == 128) begin
        check("atk128_lvl0", 128'(lvl(0)), 128'hFFFF);
        check("atk128_lvl3", 128'(lvl(3)), 128'h3800);
        check("atk128_lvl1", 128'(lvl(1)), 128'h0);
        check("atk128_active", 128'(active), 128'h09);
      end
    end

    for (int j = 1; j <= 65; j++) begin
      do_tick();
      if (j == 1)  check("dec1_lvl0", 128'(lvl(0)), 128'hFDFF);
      if (j == 63) check("dec63_lvl0", 128'(lvl(0)), 128'h81FF);
      if (j == 64) check("dec64_lvl0", 128'(lvl(0)), 128'h8102);
      if (j == 65) begin
        check("sus_hold_lvl0", 128'(lvl(0)), 128'h8102);
        check("sus_hold_lvl3", 128'(lvl(3)), 128'hBA00);
      end
    end

    sustain = 7'd127;
    do_tick();
    check("sus127_lvl0", 128'(lvl(0)), 128'hFFFF);
    check("sus127_lvl3", 128'(lvl(3)), 128'hBC00);

    gate[0] = 1'b0;
    for (int r = 1; r <= 128; r++) begin
      do_tick();
      if (r == 1)  check("rel1_lvl0", 128'(lvl(0)), 128'hFDFF);
      if (r == 33) check("rel33_lvl3", 128'(lvl(3)), 128'hFE00);
      if (r == 34) check("rel34_lvl3", 128'(lvl(3)), 128'hFFFF);
      if (r == 127) begin
        check("rel127_lvl0", 128'(lvl(0)), 128'd511);
        check("rel127_active0", 128'(active[0]), 128'd1);
      end
      if (r == 128) begin
        check("rel128_lvl0", 128'(lvl(0)), 128'd0);
        check("rel128_active", 128'(active), 128'h08);
        check("rel128_lvl3", 128'(lvl(3)), 128'hFFFF);
      end
    end
    check("no_overrun_yet", 128'(ovr_seen), 128'd0);

    gate[0] = 1'b1;
    for (int a = 1; a <= 33; a++) do_tick();
    check("retrig_pre_lvl0", 128'(lvl(0)), 128'h4200);
    gate[0] = 1'b0;
    do_tick();
    check("retrig_rel_lvl0", 128'(lvl(0)), 128'h4000);
    check("retrig_rel_active0", 128'(active[0]), 128'd1);
    gate[0] = 1'b1;
    attack = 7'd127;
    do_tick();
    check("retrig_lvl0", 128'(lvl(0)), 128'h4004);
    check("retrig_lvl3", 128'(lvl(3)), 128'hFFFF);
    check("retrig_lvl1", 128'(lvl(1)), 128'h0);
    do_tick();
    check("retrig_atk_lvl0", 128'(lvl(0)), 128'h4008);

    // Second tick three cycles into a sweep.
    done_at = 0; done_cnt = 0; ovr_at = 0; ovr_cnt = 0;
    @(negedge clock);
    tick = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clock);
      if (done) begin done_cnt++; if (done_at == 0) done_at = c; end
      if (overrun) begin ovr_cnt++; if (ovr_at == 0) ovr_at = c; end
      tick = (c == 3);
    end
    check("ovr_done_at", 128'(done_at), 128'd9);
    check("ovr_done_cnt", 128'(done_cnt), 128'd1);
    check("ovr_at", 128'(ovr_at), 128'd4);
    check("ovr_cnt", 128'(ovr_cnt), 128'd1);
    check("ovr_seen_total", 128'(ovr_seen), 128'd1);

    // Reset four cycles into a sweep aborts it without a done pulse.
    done_after = 0;
    @(negedge clock);
    tick = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clock);
      if (c == 1) tick = 1'b0;
      if (c >= 5 && done) done_after++;
      if (c == 4) reset = 1'b1;
      if (c == 5) begin
        check("midrst_level", level, 128'd0);
        check("midrst_active", 128'(active), 128'd0);
        check("midrst_overrun", 128'(overrun), 128'd0);
        reset = 1'b0;
      end
    end
    check("midrst_no_done", 128'(done_after), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/envelope_bank.md
Name: envelope_bank

Overview:
- Time-multiplexed linear ADSR envelope generator for NUM_VOICES voices, sharing one update datapath.
- Sits between the voice allocator (gates) and the wavetable/mixer pipeline (per-voice gain).
- Each audio-generation tick (50 kHz strobe from the system-clock domain), one sweep updates each voice's state and level, one voice per clock.
- Successor to the single-voice envelope: adds channel count, live sustain tracking, retrigger-from-current-level and overrun detection.

Parameters:
- NUM_VOICES, 8, voices in the bank (1..64).
- LEVEL_WIDTH, ENVELOPE_COUNTER_WIDTH (16), envelope level width.
- STEP_SHIFT, 2, left shift applied to the rate step.

Ports:
- clock  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high.
- tick  in  1  single-cycle sweep request.
- gate  in  NUM_VOICES  per-voice note-on level.
- attack, decay, release  in  7 each  percent_t rate parameters (0 = fastest).
- sustain  in  7  percent_t sustain level.
- level  out  NUM_VOICES*LEVEL_WIDTH  per-voice envelope; voice i at [i*LEVEL_WIDTH +: LEVEL_WIDTH].
- active  out  NUM_VOICES  1 when voice state != IDLE.
- done  out  1  one-cycle pulse at sweep completion.
- overrun  out  1  one-cycle pulse when tick arrives mid-sweep.

Behaviour:
- Reset: every voice IDLE; level = 0; active = 0; done = 0; overrun = 0; sweep aborted; no done pulse is issued for the aborted sweep.
- Sweep timing:
  - tick at cycle t (idle) latches attack/decay/sustain/release for the whole sweep.
  - Voice i is evaluated in cycle t+1+i; its level/active registers update at the end of that cycle.
  - done is high in cycle t+1+NUM_VOICES.
- Busy window: tick during cycles t+1..t+NUM_VOICES is ignored and pulses overrun the next cycle; the sweep continues unaffected. tick coincident with done starts a new sweep.
- Gate sampling: gate[i] is sampled in voice i's evaluation cycle. Per-voice gate_prev is stored; rise = gate & !gate_prev. Pulses between ticks are missed by design.
- Rate step: step(p) = (128 - p) << STEP_SHIFT, giving 4..512.
- Sustain level: S = {s, s, s[6:5]}, so 127 -> 0xFFFF, 64 -> 0x8102, 0 -> 0.
- Per-voice FSM, evaluated once per sweep. Priority: rise > gate low > rate update.
  - Any state with rise -> ATTACK. Level is kept (no reset to 0).
  - ATTACK: level = min(level + step(attack), 0xFFFF); on reaching 0xFFFF -> DECAY.
  - DECAY: level -= step(decay); if result <= S then level = S and state -> SUSTAIN.
  - SUSTAIN: level = S, so live sustain changes track at tick rate. sustain = 0 holds SUSTAIN at 0 and does not go IDLE.
  - ATTACK/DECAY/SUSTAIN with gate low -> RELEASE this cycle; the rate update uses the release step.
  - RELEASE: level = max(level - step(release), 0); on reaching 0 -> IDLE.
  - IDLE: level = 0; stays IDLE while gate is low.
- Arithmetic: add/subtract computed at LEVEL_WIDTH+1 bits, then saturated; no wrap-around ever.
- Gate high through RELEASE without a new rise (gate_prev high): impossible by construction, since RELEASE requires gate low.

Decomposition:
- CONFIG package additions:
  - envelope_state_t enum {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE}.
  - level_t = logic [ENVELOPE_COUNTER_WIDTH-1:0].
  - Functions rate_step(percent_t) and sustain_level(percent_t).
- Sub-module envelope_voice_step: combinational next-state/next-level for one voice (state, level, gate, gate_prev, latched params in; state, level out).
- envelope_bank holds the state/level/gate_prev arrays, voice index counter and sweep control.

Test Plan:
- Reset then one tick with gate = 0 -> done at t+9 (NUM_VOICES = 8); all levels 0; active = 0; overrun never pulses.
- gate[0] = 1, attack = 0 -> level[0] = 512*k after tick k; reaches 0xFFFF and DECAY at tick 128; active[0] = 1 from tick 1.
- Then decay = 0, sustain = 64 -> level 0xFFFF - 512*k; at tick 64 level clamps to 0x8102, SUSTAIN. Changing sustain to 127 -> next tick level = 0xFFFF.
- From 0xFFFF sustain, drop gate[0], release = 0 -> tick 127 level = 511; tick 128 level = 0, IDLE, active[0] = 0.
- Retrigger: release mid-way at level 0x4000, raise gate, attack = 127 -> next tick level = 0x4004, ATTACK. Other voices unaffected; voice 3 runs a concurrent independent envelope.
- Second tick 3 cycles after first -> overrun pulses once, done once at t+9. Reset asserted at t+4 -> no done, all levels 0 next cycle.
